// File: rtl/timer_bank.sv
// timer_bank: NUM_CH prescaled up-counters with auto-reload/one-shot, sticky W1C status and one IRQ.
// Build macro TIMER_BANK_PWM_EN adds per-channel CMP registers and the o_Pwm outputs.
module timer_bank #(
  parameter int ADDR_SEL_BITS  = 0,
  parameter int ADDR_BLOCK     = 0,
  parameter int NUM_CH         = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int PRESCALE_WIDTH = 16
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic                      i_SlaveSel,
  input  logic [29-ADDR_SEL_BITS:0] i_RegAddr,
  input  logic [3:0]                i_AV_ByteEn,
  input  logic                      i_AV_Read,
  input  logic                      i_AV_Write,
  output logic [31:0]               o_AV_ReadData,
  input  logic [31:0]               i_AV_WriteData,
  output logic                      o_AV_WaitRequest,
`ifdef TIMER_BANK_PWM_EN
  output logic [NUM_CH-1:0]         o_Pwm,
`endif
  output logic                      o_Irq
);
  localparam int AW = 30 - ADDR_SEL_BITS;

  logic [AW-3:0]             addr_hi;
  logic [1:0]                addr_off;
  logic [31:0]               be_mask;
  logic                      bus_wr;
  logic                      bus_rd;
  logic                      glob_sel;
  logic [NUM_CH-1:0]         ch_sel;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic [PRESCALE_WIDTH-1:0] pcnt;
  logic                      tick;
  logic [NUM_CH-1:0]         irq_status;
  logic [NUM_CH-1:0]         irq_enable;
  logic [NUM_CH-1:0]         w1c;
  logic [NUM_CH-1:0]         en;
  logic [NUM_CH-1:0]         oneshot;
  logic [NUM_CH-1:0]         wrap;
  logic [1:0]                ctrl_wv [NUM_CH];
  logic [CNT_WIDTH-1:0]      reload  [NUM_CH];
  logic [CNT_WIDTH-1:0]      count   [NUM_CH];
`ifdef TIMER_BANK_PWM_EN
  logic [CNT_WIDTH-1:0]      cmp     [NUM_CH];
`endif
  logic [31:0]               rd_mux;
  logic                      unused_ok;

  function automatic logic [31:0] merge_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [31:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  assign unused_ok        = (ADDR_BLOCK != 0);
  assign addr_hi          = i_RegAddr[AW-1:2];
  assign addr_off         = i_RegAddr[1:0];
  assign be_mask          = {{8{i_AV_ByteEn[3]}}, {8{i_AV_ByteEn[2]}},
                             {8{i_AV_ByteEn[1]}}, {8{i_AV_ByteEn[0]}}};
  assign bus_wr           = i_SlaveSel & i_AV_Write;
  assign bus_rd           = i_SlaveSel & i_AV_Read;
  assign glob_sel         = (addr_hi == '0);
  assign tick             = (pcnt == prescale);
  assign w1c              = (bus_wr && glob_sel && addr_off == 2'd1) ?
                            NUM_CH'(i_AV_WriteData & be_mask) : '0;
  assign o_AV_WaitRequest = 1'b0;
  assign o_Irq            = |(irq_status & irq_enable);

  // Channel n occupies word addresses 4n+4..4n+7, i.e. addr_hi == n+1.
  always_comb begin
    ch_sel = '0;
    wrap   = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      ch_sel[n]  = (addr_hi == (AW-2)'(n + 1));
      wrap[n]    = tick & en[n] & (count[n] == reload[n]);
      ctrl_wv[n] = 2'(merge_be({30'd0, oneshot[n], en[n]}, i_AV_WriteData, be_mask));
    end
  end

  always_comb begin
    rd_mux = '0;
    if (glob_sel) begin
      case (addr_off)
        2'd0:    rd_mux = 32'(prescale);
        2'd1:    rd_mux = 32'(irq_status);
        2'd2:    rd_mux = 32'(irq_enable);
        default: rd_mux = '0;
      endcase
    end
    for (int n = 0; n < NUM_CH; n++) begin
      if (ch_sel[n]) begin
        case (addr_off)
          2'd0:    rd_mux = {30'd0, oneshot[n], en[n]};
          2'd1:    rd_mux = 32'(reload[n]);
          2'd2:    rd_mux = 32'(count[n]);
          default: begin
`ifdef TIMER_BANK_PWM_EN
            rd_mux = 32'(cmp[n]);
`else
            rd_mux = '0;
`endif
          end
        endcase
      end
    end
  end

  // Read data register: one-cycle latency, zero whenever no read was sampled.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_AV_ReadData <= '0;
      prescale      <= '0;
      pcnt          <= '0;
      irq_status    <= '0;
      irq_enable    <= '0;
    end else begin
      o_AV_ReadData <= bus_rd ? rd_mux : '0;
      if (bus_wr && glob_sel && addr_off == 2'd0) begin
        prescale <= PRESCALE_WIDTH'(merge_be(32'(prescale), i_AV_WriteData, be_mask));
        pcnt     <= '0;
      end else begin
        pcnt <= tick ? '0 : pcnt + PRESCALE_WIDTH'(1);
      end
      if (bus_wr && glob_sel && addr_off == 2'd2)
        irq_enable <= NUM_CH'(merge_be(32'(irq_enable), i_AV_WriteData, be_mask));
      // A hardware wrap beats a simultaneous software clear.
      irq_status <= (irq_status & ~w1c) | wrap;
    end
  end

  // Bus writes are placed after the tick update so they win on collision.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      en      <= '0;
      oneshot <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        reload[n] <= '0;
        count[n]  <= '0;
      end
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        if (tick && en[n]) begin
          if (wrap[n]) begin
            count[n] <= '0;
            if (oneshot[n]) en[n] <= 1'b0;
          end else begin
            count[n] <= count[n] + CNT_WIDTH'(1);
          end
        end
        if (bus_wr && ch_sel[n]) begin
          case (addr_off)
            2'd0: begin
              en[n]      <= ctrl_wv[n][0];
              oneshot[n] <= ctrl_wv[n][1];
            end
            2'd1:    reload[n] <= CNT_WIDTH'(merge_be(32'(reload[n]), i_AV_WriteData, be_mask));
            2'd2:    count[n]  <= CNT_WIDTH'(merge_be(32'(count[n]), i_AV_WriteData, be_mask));
            default: ;
          endcase
        end
      end
    end
  end

`ifdef TIMER_BANK_PWM_EN
  // PWM output register: follows COUNT by one cycle.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Pwm <= '0;
      for (int n = 0; n < NUM_CH; n++) cmp[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_CH; n++) begin
        o_Pwm[n] <= en[n] && (count[n] < cmp[n]);
        if (bus_wr && ch_sel[n] && addr_off == 2'd3)
          cmp[n] <= CNT_WIDTH'(merge_be(32'(cmp[n]), i_AV_WriteData, be_mask));
      end
    end
  end
`endif

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank (default parameters) with a register-level reference model.
`timescale 1ns/1ps
module tb_timer_bank;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic [29:0] addr;
  logic [3:0]  be;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic [31:0] wdata;
  logic        waitreq;
  logic        irq;
`ifdef TIMER_BANK_PWM_EN
  logic [NCH-1:0] pwm;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  timer_bank dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_SlaveSel(sel), .i_RegAddr(addr),
    .i_AV_ByteEn(be), .i_AV_Read(rd), .i_AV_Write(wr), .o_AV_ReadData(rdata),
    .i_AV_WriteData(wdata), .o_AV_WaitRequest(waitreq),
`ifdef TIMER_BANK_PWM_EN
    .o_Pwm(pwm),
`endif
    .o_Irq(irq)
  );

  // Reference model: programmer-visible registers, advanced once per clock.
  logic [15:0]    m_pre, m_pcnt, nx_pre, nx_pcnt;
  logic [NCH-1:0] m_stat, m_ien, m_en, m_os, m_pwm;
  logic [NCH-1:0] nx_stat, nx_ien, nx_en, nx_os, nx_pwm, nx_set;
  logic [31:0]    m_rel [NCH], m_cnt [NCH], m_cmp [NCH];
  logic [31:0]    nx_rel[NCH], nx_cnt[NCH], nx_cmp[NCH];
  logic [31:0]    m_rd, nx_rd, nx_old, nx_nv, nx_wm;
  logic           nx_tick;
  int             nx_a;

  function automatic logic [31:0] model_read(input int a);
    int ch;
    if (a == 0) return {16'd0, m_pre};
    if (a == 1) return {28'd0, m_stat};
    if (a == 2) return {28'd0, m_ien};
    if (a >= 4 && a < 4 + 4 * NCH) begin
      ch = (a - 4) / 4;
      case ((a - 4) % 4)
        0: return {30'd0, m_os[ch], m_en[ch]};
        1: return m_rel[ch];
        2: return m_cnt[ch];
        default: begin
`ifdef TIMER_BANK_PWM_EN
          return m_cmp[ch];
`else
          return 32'd0;
`endif
        end
      endcase
    end
    return 32'd0;
  endfunction

  always_comb begin
    nx_a    = int'(addr);
    nx_old  = model_read(nx_a);
    nx_rd   = (sel && rd) ? nx_old : 32'd0;
    nx_tick = (m_pcnt == m_pre);
    nx_pcnt = nx_tick ? 16'd0 : m_pcnt + 16'd1;
    nx_pre  = m_pre;
    nx_stat = m_stat;
    nx_ien  = m_ien;
    nx_en   = m_en;
    nx_os   = m_os;
    nx_set  = '0;
    nx_pwm  = '0;
    nx_nv   = nx_old;
    nx_wm   = 32'd0;
    for (int ch = 0; ch < NCH; ch++) begin
      nx_rel[ch] = m_rel[ch];
      nx_cmp[ch] = m_cmp[ch];
      nx_cnt[ch] = m_cnt[ch];
      nx_pwm[ch] = m_en[ch] && (m_cnt[ch] < m_cmp[ch]);
      if (nx_tick && m_en[ch]) begin
        if (m_cnt[ch] == m_rel[ch]) begin
          nx_cnt[ch] = 32'd0;
          nx_set[ch] = 1'b1;
          if (m_os[ch]) nx_en[ch] = 1'b0;
        end else begin
          nx_cnt[ch] = m_cnt[ch] + 32'd1;
        end
      end
    end
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        nx_nv[8*b +: 8] = wdata[8*b +: 8];
        nx_wm[8*b +: 8] = wdata[8*b +: 8];
      end
    end
    if (sel && wr) begin
      if (nx_a == 0) begin
        nx_pre  = nx_nv[15:0];
        nx_pcnt = 16'd0;
      end else if (nx_a == 1) begin
        nx_stat = m_stat & ~nx_wm[NCH-1:0];
      end else if (nx_a == 2) begin
        nx_ien = nx_nv[NCH-1:0];
      end else if (nx_a >= 4 && nx_a < 4 + 4 * NCH) begin
        case ((nx_a - 4) % 4)
          0: begin
            nx_en[(nx_a - 4) / 4] = nx_nv[0];
            nx_os[(nx_a - 4) / 4] = nx_nv[1];
          end
          1: nx_rel[(nx_a - 4) / 4] = nx_nv;
          2: nx_cnt[(nx_a - 4) / 4] = nx_nv;
          default: begin
`ifdef TIMER_BANK_PWM_EN
            nx_cmp[(nx_a - 4) / 4] = nx_nv;
`endif
          end
        endcase
      end
    end
    nx_stat = nx_stat | nx_set;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pre <= '0; m_pcnt <= '0; m_stat <= '0; m_ien <= '0;
      m_en <= '0; m_os <= '0; m_pwm <= '0; m_rd <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        m_rel[ch] <= '0; m_cnt[ch] <= '0; m_cmp[ch] <= '0;
      end
    end else begin
      m_pre <= nx_pre; m_pcnt <= nx_pcnt; m_stat <= nx_stat; m_ien <= nx_ien;
      m_en <= nx_en; m_os <= nx_os; m_pwm <= nx_pwm; m_rd <= nx_rd;
      for (int ch = 0; ch < NCH; ch++) begin
        m_rel[ch] <= nx_rel[ch]; m_cnt[ch] <= nx_cnt[ch]; m_cmp[ch] <= nx_cmp[ch];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("rdata_model", rdata, m_rd);
      check("irq_model", {31'd0, irq}, {31'd0, |(m_stat & m_ien)});
      check("waitreq", {31'd0, waitreq}, 32'd0);
`ifdef TIMER_BANK_PWM_EN
      check("pwm_model", {28'd0, pwm}, {28'd0, m_pwm});
`endif
    end
  end

  task automatic bus_write(input int a, input logic [31:0] d, input logic [3:0] b);
    sel = 1'b1; wr = 1'b1; addr = 30'(a); wdata = d; be = b;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; be = 4'h0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    sel = 1'b1; rd = 1'b1; addr = 30'(a); be = 4'hF;
    @(negedge clk);
    d = rdata;
    sel = 1'b0; rd = 1'b0; be = 4'h0;
  endtask

  task automatic rd_check(input string name, input int a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic wait_irq(input int limit, output int t);
    int k;
    k = 0;
    t = -1;
    while (!irq && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (irq) t = cyc;
    else begin
      vectors++;
      miscompares++;
      $display("FAIL irq_timeout: got no interrupt, expected one within %0d cycles", limit);
    end
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 3; a++) rd_check(name, a, 32'd0);
    for (int a = 4; a < 4 + 4 * NCH; a++) rd_check(name, a, 32'd0);
    check({name, "_irq"}, {31'd0, irq}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int t0, t1, highs;
    rst_n = 1'b0; sel = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; be = 4'h0; wdata = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    read_all_zero("reset_state");

    // Byte enables and truncation on PRESCALE (16 bits wide).
    bus_write(0, 32'hFFFF_FFFF, 4'b0001);
    rd_check("prescale_be0", 0, 32'h0000_00FF);
    bus_write(0, 32'h0001_2345, 4'b1111);
    rd_check("prescale_trunc", 0, 32'h0000_2345);
    bus_write(0, 32'h0000_AB00, 4'b0010);
    rd_check("prescale_be1", 0, 32'h0000_AB45);
    bus_write(0, 32'd0, 4'hF);

    // Auto-reload on CH0.
    bus_write(5, 32'd3, 4'hF);
    bus_write(2, 32'd1, 4'hF);
    bus_write(4, 32'd1, 4'hF);
    rd_check("count_seq0", 6, 32'd0);
    rd_check("count_seq1", 6, 32'd1);
    rd_check("count_seq2", 6, 32'd2);
    rd_check("count_seq3", 6, 32'd3);
    rd_check("count_seq4", 6, 32'd0);
    check("irq_after_wrap", {31'd0, irq}, 32'd1);
    rd_check("status_wrap", 1, 32'd1);
    bus_write(4, 32'd0, 4'hF);
    bus_write(1, 32'd1, 4'hF);
    check("irq_after_w1c", {31'd0, irq}, 32'd0);
    rd_check("status_w1c", 1, 32'd0);

    // W1C colliding with the wrap edge: set wins.
    bus_write(6, 32'd0, 4'hF);
    bus_write(1, 32'hF, 4'hF);
    bus_write(4, 32'd1, 4'hF);
    repeat (3) @(negedge clk);
    bus_write(1, 32'd1, 4'hF);
    bus_write(4, 32'd0, 4'hF);
    rd_check("w1c_collision", 1, 32'd1);
    bus_write(1, 32'd1, 4'hF);

    // COUNT write colliding with a tick: write wins.
    bus_write(4, 32'd1, 4'hF);
    @(negedge clk);
    bus_write(6, 32'd7, 4'hF);
    rd_check("count_write_collision", 6, 32'd7);
    bus_write(4, 32'd0, 4'hF);
    bus_write(6, 32'd0, 4'hF);

    // One-shot on CH2.
    bus_write(13, 32'd5, 4'hF);
    bus_write(12, 32'd3, 4'hF);
    repeat (12) @(negedge clk);
    rd_check("oneshot_ctrl", 12, 32'd2);
    rd_check("oneshot_count", 14, 32'd0);
    rd_check("oneshot_status", 1, 32'd4);
    bus_write(1, 32'd4, 4'hF);
    repeat (20) @(negedge clk);
    rd_check("oneshot_no_rewrap", 1, 32'd0);
    rd_check("oneshot_count_hold", 14, 32'd0);

    // Prescaler: CH1 period 6, CH0 period 15, both running.
    bus_write(0, 32'd2, 4'hF);
    bus_write(5, 32'd4, 4'hF);
    bus_write(9, 32'd1, 4'hF);
    bus_write(2, 32'd2, 4'hF);
    bus_write(8, 32'd1, 4'hF);
    bus_write(4, 32'd1, 4'hF);
    wait_irq(40, t0);
    bus_write(1, 32'd2, 4'hF);
    wait_irq(40, t1);
    check("ch1_period", 32'(t1 - t0), 32'd6);
    bus_write(2, 32'd1, 4'hF);
    bus_write(1, 32'd3, 4'hF);
    wait_irq(60, t0);
    bus_write(1, 32'd1, 4'hF);
    wait_irq(60, t1);
    check("ch0_period", 32'(t1 - t0), 32'd15);
    bus_write(4, 32'd0, 4'hF);
    bus_write(8, 32'd0, 4'hF);
    bus_write(0, 32'd0, 4'hF);
    bus_write(1, 32'hF, 4'hF);

    // Unmapped space and channels beyond NUM_CH.
    rd_check("unmapped_3", 3, 32'd0);
    bus_write(20, 32'd1, 4'hF);
    rd_check("ch4_ctrl", 20, 32'd0);
    rd_check("ch4_count", 22, 32'd0);
    rd_check("unmapped_100", 100, 32'd0);
`ifndef TIMER_BANK_PWM_EN
    bus_write(7, 32'h55, 4'hF);
    rd_check("cmp_absent", 7, 32'd0);
`else
    // PWM: RELOAD=9, CMP=3 gives 3 high cycles out of every 10.
    bus_write(6, 32'd0, 4'hF);
    bus_write(5, 32'd9, 4'hF);
    bus_write(7, 32'd3, 4'hF);
    rd_check("cmp_readback", 7, 32'd3);
    bus_write(4, 32'd1, 4'hF);
    repeat (5) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      if (pwm[0]) highs++;
      @(negedge clk);
    end
    check("pwm_duty", 32'(highs), 32'd12);
    bus_write(4, 32'd0, 4'hF);
`endif

    // Asynchronous reset in the middle of counting.
    bus_write(2, 32'd1, 4'hF);
    bus_write(4, 32'd1, 4'hF);
    repeat (10) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_irq", {31'd0, irq}, 32'd0);
    check("async_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_all_zero("after_reset");
`ifdef TIMER_BANK_PWM_EN
    for (int ch = 0; ch < NCH; ch++) rd_check("after_reset_cmp", 7 + 4 * ch, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
# timer_bank

Multi-channel, parametrised timer/counter peripheral on the Avalon data bus. It is the successor to the single-channel overflow counter. It provides NUM_CH independent up-counters of configurable width, driven by a shared programmable prescaler. Each channel has auto-reload and one-shot modes, sticky per-channel overflow status with write-1-to-clear, and a single maskable interrupt line to the CPU.

## Interface
- ADDR_SEL_BITS, 0: upper address bits consumed by the bus decoder; sets i_RegAddr width.
- ADDR_BLOCK, 0: decoder block index; not used internally.
- NUM_CH, 4: number of channels, 1..8.
- CNT_WIDTH, 32: counter, reload and compare width, 8..32.
- PRESCALE_WIDTH, 16: prescaler width, 1..32.

Ports (one clock; reset is asynchronous and active-low):
- i_Clk  in  1  system clock; all state changes on the rising edge.
- i_Rst_n  in  1  asynchronous active-low reset.
- i_SlaveSel  in  1  block selected by the bus decoder.
- i_RegAddr  in  30-ADDR_SEL_BITS  word address within the block.
- i_AV_ByteEn  in  4  write byte enables.
- i_AV_Read  in  1  read strobe.
- i_AV_Write  in  1  write strobe.
- o_AV_ReadData  out  32  read data, registered.
- i_AV_WriteData  in  32  write data.
- o_AV_WaitRequest  out  1  tied 0.
- o_Irq  out  1  level interrupt, equal to |(IRQ_STATUS & IRQ_ENABLE).

## Operation
- Register map (word addresses):
  - 0 PRESCALE, PRESCALE_WIDTH bits.
  - 1 IRQ_STATUS, bits [NUM_CH-1:0]; read returns status; writing 1 clears a bit.
  - 2 IRQ_ENABLE, bits [NUM_CH-1:0].
  - For channel n at base 4+4n:
    - +0 CTRL: bit0 EN, bit1 ONESHOT.
    - +1 RELOAD.
    - +2 COUNT: read returns the live count; write loads it.
    - +3 CMP (PWM build only).
  - Unmapped addresses and channels ≥ NUM_CH read 0; writes to them are ignored.
- Byte enables apply per byte on all writes. Written values are truncated to field width. Reads zero-extend.
- Prescaler:
  - Free-running counter pcnt.
  - tick=1 in any cycle where pcnt==PRESCALE; pcnt then returns to 0, otherwise it increments.
  - PRESCALE=0 gives a tick every cycle.
  - Writing PRESCALE resets pcnt to 0.
- Channel n on a tick while EN=1:
  - If COUNT==RELOAD: COUNT←0, IRQ_STATUS[n]←1, and EN←0 if ONESHOT=1.
  - Otherwise COUNT←COUNT+1.
  - EN=0 holds COUNT.
  - RELOAD=0 wraps on every tick.
  - If COUNT>RELOAD (written by software), COUNT increments until it reaches 2^CNT_WIDTH−1, rolls to 0, then continues normally. Rollover does not set status.
- Simultaneous events:
  - Hardware status set and software W1C on the same bit in the same cycle: the set wins.
  - Software COUNT write and a tick in the same cycle: the write wins.
  - Software CTRL write and a one-shot EN clear in the same cycle: the write wins.
- Reset mid-operation clears all state immediately, regardless of clock.

## Timing
- Reset values: o_AV_ReadData=0, o_Irq=0, o_Pwm=0. All registers, pcnt and counters are 0.
- Read latency is one cycle. o_AV_ReadData is valid the cycle after i_SlaveSel&i_AV_Read, and is 0 in every other cycle.
- A write takes effect on the edge where it is sampled; read-back is valid from the next transaction.
- Status bit asserts on the edge where COUNT wraps. o_Irq is combinational from registers, so it is high from that edge onward.
- Period of a free-running channel is (PRESCALE+1)×(RELOAD+1) cycles.

## Configuration
- TIMER_BANK_PWM_EN defined:
  - Adds per-channel CMP registers and port o_Pwm, out, NUM_CH bits.
  - o_Pwm[n] is registered, equal to EN && (COUNT < CMP), and updates one cycle after COUNT.
- TIMER_BANK_PWM_EN undefined:
  - No CMP storage; offset +3 reads 0 and writes are ignored.
  - o_Pwm port is absent.

## Test plan
- Reset:
  - Assert i_Rst_n=0 asynchronously mid-count, then read every mapped address.
  - All reads return 0; o_Irq=0.
- Auto-reload:
  - PRESCALE=0, CH0 RELOAD=3, IRQ_ENABLE=1, then CTRL=1.
  - COUNT sequence is 0,1,2,3,0. IRQ_STATUS=1 and o_Irq=1 from the wrap edge; W1C 1 drops o_Irq.
- Prescaler:
  - PRESCALE=2, CH1 RELOAD=1.
  - Status bit1 sets every 6 cycles. Period is unchanged when CH0 runs concurrently with RELOAD=4 (CH0 period 15).
- One-shot:
  - CH2 CTRL=3, RELOAD=5.
  - After the wrap: CTRL reads 2, COUNT holds 0, status bit2=1, and there are no further wraps in the next 20 cycles.
- Collision:
  - W1C on bit0 issued on the same edge CH0 wraps: status bit0 reads 1.
  - COUNT write of 7 coincident with a tick: COUNT reads 7.
- PWM (macro defined):
  - PRESCALE=0, RELOAD=9, CMP=3, EN=1.
  - o_Pwm[0] is high for 3 of every 10 cycles, continuously repeated.
